// File: rtl/wasm_prog_loader_pkg.sv
// Shared types and defaults for the WASM program loader.
package wasm_prog_loader_pkg;

  // Default instruction BRAM address width (depth = 2**ADDR_W bytes).
  localparam int unsigned InstrLog2BramDepth = 10;

  // Default run-cycle budget before the core is declared hung.
  localparam logic [31:0] DefaultTimeoutCyc = 32'd1_000_000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,  // also receives the low length byte
    StLenHi = 3'd1,
    StLoad  = 3'd2,
    StArm   = 3'd3,
    StRun   = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    StatusOk          = 3'd0,
    StatusInstrErr    = 3'd1,
    StatusStackExceed = 3'd2,
    StatusEmptyPop    = 3'd3,
    StatusTimeout     = 3'd4,
    StatusLenBad      = 3'd5
  } status_e;

  // Fault status with fixed priority; StatusOk when no fault flag is set.
  function automatic status_e fault_status(input logic instr_error,
                                           input logic stack_exceed,
                                           input logic stack_empty);
    if (instr_error) begin
      return StatusInstrErr;
    end else if (stack_exceed) begin
      return StatusStackExceed;
    end else if (stack_empty) begin
      return StatusEmptyPop;
    end
    return StatusOk;
  endfunction

endpackage

// File: rtl/wasm_prog_loader.sv
// Streams a length-prefixed WASM image into instruction BRAM, then runs the core
// and reports how it ended together with the number of run cycles.
module wasm_prog_loader
  import wasm_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = InstrLog2BramDepth,
  parameter logic [31:0] TIMEOUT_CYC = DefaultTimeoutCyc
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic              i_clear,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [7:0]        o_bram_wdata,
  output logic              o_core_rst_n,
  input  logic              i_instr_finish,
  input  logic              i_instr_error,
  input  logic              i_stack_exceed,
  input  logic              i_stack_empty,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_status,
  output logic [31:0]       o_cycle_cnt
);

  localparam logic [31:0] Depth = 32'(64'd1 << ADDR_W);

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [7:0]          bram_wdata_q, bram_wdata_d;
  status_e             status_q, status_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                s_ready;
  logic                hs;
  logic [15:0]         len_full;
  logic                len_bad;
  logic                last_byte;
  logic                fault_any;
  logic                timeout_hit;
  logic                term_q, term_d;

  // Handshake and decode helpers shared by the next-state and datapath logic.
  always_comb begin
    s_ready     = ((state_q == StIdle) || (state_q == StLenHi) || (state_q == StLoad)) && !i_rst;
    hs          = i_s_valid && s_ready;
    len_full    = {i_s_data, len_lo_q};
    len_bad     = (len_full == 16'd0) || (32'(len_full) > Depth);
    last_byte   = (32'(wr_ptr_q) == (32'(len_q) - 32'd1));
    fault_any   = i_instr_error || i_stack_exceed || i_stack_empty;
    timeout_hit = (cnt_q == (TIMEOUT_CYC - 32'd1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StLenHi;
      StLenHi: if (hs) state_d = len_bad ? StErr : StLoad;
      StLoad:  if (hs && last_byte) state_d = StArm;
      StArm:   state_d = StRun;
      StRun: begin
        if (fault_any) begin
          state_d = StErr;
        end else if (i_instr_finish) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StDone, StErr: if (i_clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: length capture, BRAM write staging, status and run counter.
  always_comb begin
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    status_d     = status_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hs) len_lo_d = i_s_data;
      end
      StLenHi: begin
        if (hs) begin
          len_d    = len_full;
          wr_ptr_d = '0;
          if (len_bad) status_d = StatusLenBad;
        end
      end
      StLoad: begin
        if (hs) begin
          bram_we_d    = 1'b1;
          bram_addr_d  = wr_ptr_q;
          bram_wdata_d = i_s_data;
          wr_ptr_d     = wr_ptr_q + 1'b1;
        end
      end
      StArm: begin
        cnt_d = '0;
      end
      StRun: begin
        // The exit cycle is not counted; flags beat the timeout in the same cycle.
        if (fault_any) begin
          status_d = fault_status(i_instr_error, i_stack_exceed, i_stack_empty);
        end else if (i_instr_finish) begin
          status_d = StatusOk;
        end else if (timeout_hit) begin
          status_d = StatusTimeout;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone, StErr: begin
        if (i_clear) begin
          status_d = StatusOk;
          cnt_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // Done pulse fires only on the first cycle in DONE or ERR.
  always_comb begin
    term_d = (state_d == StDone) || (state_d == StErr);
    done_d = term_d && !term_q;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_lo_q     <= '0;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      status_q     <= StatusOk;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      term_q       <= 1'b0;
    end else begin
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      status_q     <= status_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      term_q       <= term_d;
    end
  end

  // Outputs; core is released only while running and never during reset.
  always_comb begin
    o_s_ready    = s_ready;
    o_bram_we    = bram_we_q;
    o_bram_addr  = bram_addr_q;
    o_bram_wdata = bram_wdata_q;
    o_core_rst_n = (state_q == StRun) && !i_rst;
    o_busy       = (state_q == StLenHi) || (state_q == StLoad) ||
                   (state_q == StArm) || (state_q == StRun);
    o_done       = done_q;
    o_status     = status_q;
    o_cycle_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_wasm_prog_loader.sv
// Scoreboard bench for wasm_prog_loader: stimulus pushes expected BRAM writes and
// run results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_wasm_prog_loader;

  localparam int unsigned AW = 4;  // depth 16

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cnt;
    int          cyc;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          clear = 1'b0;
  logic          fin = 1'b0, ierr = 1'b0, sexc = 1'b0, semp = 1'b0;

  logic          s_ready, bram_we, core_rst_n, busy, done;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic [2:0]    status;
  logic [31:0]   cycle_cnt;

  logic          s_ready2, bram_we2, core_rst_n2, busy2, done2;
  logic [AW-1:0] bram_addr2;
  logic [7:0]    bram_wdata2;
  logic [2:0]    status2;
  logic [31:0]   cycle_cnt2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_hs = 0;
  bit   watch2 = 1'b0;
  wr_t  wq[$];
  res_t rq[$];
  res_t rq2[$];
  logic [7:0] pl[$];

  wasm_prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(32'd1000)) dut (
    .i_clk(clk), .i_rst(rst), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_clear(clear), .o_bram_we(bram_we), .o_bram_addr(bram_addr), .o_bram_wdata(bram_wdata),
    .o_core_rst_n(core_rst_n), .i_instr_finish(fin), .i_instr_error(ierr),
    .i_stack_exceed(sexc), .i_stack_empty(semp), .o_busy(busy), .o_done(done),
    .o_status(status), .o_cycle_cnt(cycle_cnt)
  );

  // Second instance with a short budget; its core never raises a flag.
  wasm_prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(32'd16)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready2),
    .i_clear(clear), .o_bram_we(bram_we2), .o_bram_addr(bram_addr2),
    .o_bram_wdata(bram_wdata2), .o_core_rst_n(core_rst_n2), .i_instr_finish(1'b0),
    .i_instr_error(1'b0), .i_stack_exceed(1'b0), .i_stack_empty(1'b0), .o_busy(busy2),
    .o_done(done2), .o_status(status2), .o_cycle_cnt(cycle_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bram_we) begin
      if (wq.size() == 0) begin
        chk("unexpected bram write", 1'b1, 1'b0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("bram addr", 64'(bram_addr), 64'(w.addr));
        chk("bram data", 64'(bram_wdata), 64'(w.data));
        chk("bram write cycle", 64'(cyc), 64'(w.cyc));
      end
    end
    if (done) begin
      if (rq.size() == 0) begin
        chk("unexpected done", 1'b1, 1'b0);
      end else begin
        res_t r;
        r = rq.pop_front();
        chk("status", 64'(status), 64'(r.st));
        chk("cycle count", 64'(cycle_cnt), 64'(r.cnt));
        chk("done cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (done2 && watch2) begin
      if (rq2.size() == 0) begin
        chk("unexpected done (timeout dut)", 1'b1, 1'b0);
      end else begin
        res_t r;
        r = rq2.pop_front();
        chk("timeout status", 64'(status2), 64'(r.st));
        chk("timeout count", 64'(cycle_cnt2), 64'(r.cnt));
        chk("timeout done cycle", 64'(cyc), 64'(r.cyc));
      end
    end
  end

  // Present one byte at a negedge, wait (bounded) for ready, return one negedge later.
  task automatic send_byte(input logic [7:0] b, input bit exp_wr, input int addr);
    int t = 0;
    s_data  = b;
    s_valid = 1'b1;
    #1;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("ready wait", 1'b0, 1'b1);
    last_hs = cyc;
    if (exp_wr) begin
      wr_t w;
      w.addr = AW'(addr);
      w.data = b;
      w.cyc  = cyc + 1;
      wq.push_back(w);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic load_frame(input int len, input bit gaps);
    send_byte(len[7:0], 1'b0, 0);
    send_byte(len[15:8], 1'b0, 0);
    for (int i = 0; i < pl.size(); i++) begin
      send_byte(pl[i], 1'b1, i);
      if (gaps && i < pl.size() - 1) @(negedge clk);
    end
  endtask

  task automatic len_err(input logic [15:0] len);
    res_t r;
    send_byte(len[7:0], 1'b0, 0);
    r.st  = 3'd5;
    r.cnt = 32'd0;
    r.cyc = cyc + 1;
    rq.push_back(r);
    send_byte(len[15:8], 1'b0, 0);
    #1;
    chk("ready after bad len", s_ready, 1'b0);
    chk("core held after bad len", core_rst_n, 1'b0);
    @(negedge clk);
  endtask

  // Wait for core release, raise flags in RUN cycle n, then check the held result.
  task automatic run_core(input int n, input bit f, input bit ie, input bit se, input bit sp,
                          input logic [2:0] est, input logic [31:0] ecnt, input bit to2);
    int t = 0;
    res_t r;
    while (!core_rst_n && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("core rst_n rise cycle", 64'(cyc), 64'(last_hs + 2));
    if (to2) begin
      r.st  = 3'd4;
      r.cnt = 32'd15;
      r.cyc = cyc + 16;
      rq2.push_back(r);
    end
    repeat (n - 1) @(negedge clk);
    chk("busy in run", busy, 1'b1);
    fin  = f;
    ierr = ie;
    sexc = se;
    semp = sp;
    r.st  = est;
    r.cnt = ecnt;
    r.cyc = cyc + 1;
    rq.push_back(r);
    @(negedge clk);
    {fin, ierr, sexc, semp} = '0;
    @(negedge clk);
    chk("done is a pulse", done, 1'b0);
    chk("status held", 64'(status), 64'(est));
    chk("count held", cycle_cnt, ecnt);
    chk("core held after run", core_rst_n, 1'b0);
    chk("not busy after run", busy, 1'b0);
  endtask

  task automatic do_clear();
    int t = 0;
    while ((busy || busy2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("clear wait bound", 64'(t < 100), 64'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("status after clear", 64'(status), 64'(0));
    chk("count after clear", cycle_cnt, 32'd0);
    chk("ready after clear", s_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    @(negedge clk);
    chk("ready during reset", s_ready, 1'b0);
    chk("core rst_n during reset", core_rst_n, 1'b0);
    @(negedge clk);
    chk("reset we", bram_we, 1'b0);
    chk("reset addr", 64'(bram_addr), 64'(0));
    chk("reset wdata", 64'(bram_wdata), 64'(0));
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset status", 64'(status), 64'(0));
    chk("reset count", cycle_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready in idle", s_ready, 1'b1);

    // Basic load and finish on the 38th RUN cycle.
    pl = '{8'h41, 8'h0F, 8'h20, 8'h00, 8'h0B};
    load_frame(5, 1'b0);
    run_core(38, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd37, 1'b0);
    do_clear();

    // Bad lengths: zero and one past the depth.
    len_err(16'd0);
    do_clear();
    len_err(16'd17);
    do_clear();

    // Full-depth image with valid toggling; finish in the first RUN cycle.
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 3));
    load_frame(16, 1'b1);
    run_core(1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    do_clear();

    // Simultaneous instr_error, stack_exceed and finish.
    pl = '{8'hAA, 8'h55, 8'h01};
    load_frame(3, 1'b0);
    run_core(3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'd2, 1'b0);
    do_clear();

    // Stack exceed alone, then empty pop alone.
    pl = '{8'h10, 8'h20};
    load_frame(2, 1'b0);
    run_core(5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'd4, 1'b0);
    do_clear();
    pl = '{8'h7E};
    load_frame(1, 1'b0);
    run_core(2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'd1, 1'b0);
    do_clear();

    // Timeout on the 16-cycle instance while the main instance runs on.
    watch2 = 1'b1;
    pl = '{8'hC3, 8'h3C};
    load_frame(2, 1'b0);
    run_core(25, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd24, 1'b1);
    chk("timeout core held", core_rst_n2, 1'b0);
    chk("timeout status held", 64'(status2), 64'(4));
    chk("timeout count held", cycle_cnt2, 32'd15);
    do_clear();
    watch2 = 1'b0;

    // Reset while presenting payload byte 3, then a fresh frame.
    send_byte(8'd5, 1'b0, 0);
    send_byte(8'd0, 1'b0, 0);
    send_byte(8'h91, 1'b1, 0);
    send_byte(8'h92, 1'b1, 1);
    send_byte(8'h93, 1'b1, 2);
    s_data  = 8'h94;
    s_valid = 1'b1;
    rst     = 1'b1;
    #1;
    chk("ready masked by reset", s_ready, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    chk("mid-load reset we", bram_we, 1'b0);
    chk("mid-load reset addr", 64'(bram_addr), 64'(0));
    chk("mid-load reset wdata", 64'(bram_wdata), 64'(0));
    chk("mid-load reset busy", busy, 1'b0);
    chk("mid-load reset core", core_rst_n, 1'b0);
    chk("mid-load reset status", 64'(status), 64'(0));
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_frame(4, 1'b0);
    run_core(10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd9, 1'b0);
    do_clear();

    repeat (3) @(negedge clk);
    chk("write queue drained", 64'(wq.size()), 64'(0));
    chk("result queue drained", 64'(rq.size()), 64'(0));
    chk("timeout queue drained", 64'(rq2.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
